// File: rtl/idu_exu_pipe.sv
// Decode-to-execute pipeline register with a two-entry skid buffer (out + skid).
// The upstream ready is registered; same-cycle GPR writebacks are forwarded into buffered operands.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif

module idu_exu_pipe #(
  parameter int unsigned DEC_INFO_W = `DECINFO_WIDTH,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_valid_i,
  output logic                  inst_ready_o,
  input  logic [31:0]           inst_i,
  input  logic [DEC_INFO_W-1:0] dec_info_bus_i,
  input  logic [31:0]           dec_imm_i,
  input  logic [31:0]           dec_pc_i,
  input  logic [31:0]           next_pc_i,
  input  logic [4:0]            rd_waddr_i,
  input  logic                  rd_we_i,
  input  logic [4:0]            rs1_raddr_i,
  input  logic [4:0]            rs2_raddr_i,
  input  logic [31:0]           reg1_rdata_i,
  input  logic [31:0]           reg2_rdata_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_waddr_i,
  input  logic [31:0]           wb_wdata_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_o,
  output logic [DEC_INFO_W-1:0] dec_info_bus_o,
  output logic [31:0]           dec_imm_o,
  output logic [31:0]           dec_pc_o,
  output logic [31:0]           next_pc_o,
  output logic [4:0]            rd_waddr_o,
  output logic                  rd_we_o,
  output logic [31:0]           reg1_rdata_o,
  output logic [31:0]           reg2_rdata_o
);

  typedef struct packed {
    logic [31:0]           inst;
    logic [DEC_INFO_W-1:0] info;
    logic [31:0]           imm;
    logic [31:0]           pc;
    logic [31:0]           npc;
    logic [4:0]            rd;
    logic                  rd_we;
    logic [31:0]           r1;
    logic [31:0]           r2;
  } entry_t;

  // Encoding is {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam entry_t ENTRY_RST = '{inst: NOP_INST, default: '0};

  state_e     state_q, state_d;
  entry_t     out_q, out_d;
  entry_t     skid_q, skid_d;
  logic [4:0] skid_rs1_q, skid_rs1_d;
  logic [4:0] skid_rs2_q, skid_rs2_d;
  logic       ready_q, ready_d;

  logic   out_valid;
  logic   consume;
  logic   accept;
  entry_t in_entry;
  entry_t skid_fwd;

  function automatic logic wb_match(input logic [4:0] raddr);
    return wb_we_i && (wb_waddr_i != 5'd0) && (wb_waddr_i == raddr);
  endfunction

  assign out_valid = (state_q != EMPTY);
  assign consume   = out_valid && !hold_i;
  assign accept    = inst_valid_i && ready_q;

  always_comb begin
    in_entry.inst  = inst_i;
    in_entry.info  = dec_info_bus_i;
    in_entry.imm   = dec_imm_i;
    in_entry.pc    = dec_pc_i;
    in_entry.npc   = next_pc_i;
    in_entry.rd    = rd_waddr_i;
    in_entry.rd_we = rd_we_i;
    in_entry.r1    = wb_match(rs1_raddr_i) ? wb_wdata_i : reg1_rdata_i;
    in_entry.r2    = wb_match(rs2_raddr_i) ? wb_wdata_i : reg2_rdata_i;
  end

  // Skid operands are patched every cycle they are valid, including the cycle they move to out.
  always_comb begin
    skid_fwd = skid_q;
    if (state_q == FULL) begin
      if (wb_match(skid_rs1_q)) skid_fwd.r1 = wb_wdata_i;
      if (wb_match(skid_rs2_q)) skid_fwd.r2 = wb_wdata_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    skid_d     = skid_fwd;
    skid_rs1_d = skid_rs1_q;
    skid_rs2_d = skid_rs2_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            out_d   = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (consume && accept) begin
            out_d = in_entry;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d     = in_entry;
            skid_rs1_d = rs1_raddr_i;
            skid_rs2_d = rs2_raddr_i;
            state_d    = FULL;
          end
        end
        FULL: begin
          if (consume) begin
            out_d   = skid_fwd;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_q      <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      skid_rs1_q <= '0;
      skid_rs2_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      skid_rs1_q <= skid_rs1_d;
      skid_rs2_q <= skid_rs2_d;
      ready_q    <= ready_d;
    end
  end

  assign inst_ready_o   = ready_q;
  assign inst_valid_o   = out_valid;
  assign inst_o         = out_valid ? out_q.inst : NOP_INST;
  assign dec_info_bus_o = out_valid ? out_q.info : '0;
  assign rd_we_o        = out_valid && out_q.rd_we;
  assign dec_imm_o      = out_q.imm;
  assign dec_pc_o       = out_q.pc;
  assign next_pc_o      = out_q.npc;
  assign rd_waddr_o     = out_q.rd;
  assign reg1_rdata_o   = out_q.r1;
  assign reg2_rdata_o   = out_q.r2;

endmodule

// File: tb/tb_idu_exu_pipe.sv
// Self-checking bench for idu_exu_pipe: directed scenarios plus randomized traffic
// against a queue-based reference model of the two-entry stage.
module tb_idu_exu_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid_i, inst_ready_o;
  logic [31:0] inst_i, dec_info_bus_i, dec_imm_i, dec_pc_i, next_pc_i;
  logic [4:0]  rd_waddr_i, rs1_raddr_i, rs2_raddr_i;
  logic        rd_we_i;
  logic [31:0] reg1_rdata_i, reg2_rdata_i;
  logic        hold_i, flush_i, wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        inst_valid_o, rd_we_o;
  logic [31:0] inst_o, dec_info_bus_o, dec_imm_o, dec_pc_o, next_pc_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] reg1_rdata_o, reg2_rdata_o;

  idu_exu_pipe #(.DEC_INFO_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .dec_info_bus_i(dec_info_bus_i), .dec_imm_i(dec_imm_i),
    .dec_pc_i(dec_pc_i), .next_pc_i(next_pc_i),
    .rd_waddr_i(rd_waddr_i), .rd_we_i(rd_we_i),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .hold_i(hold_i), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .dec_info_bus_o(dec_info_bus_o),
    .dec_imm_o(dec_imm_o), .dec_pc_o(dec_pc_o), .next_pc_o(next_pc_o),
    .rd_waddr_o(rd_waddr_o), .rd_we_o(rd_we_o),
    .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, info, imm, pc, npc;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_we;
    logic [31:0] r1, r2;
  } bundle_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference: an in-order queue of at most two bundles; head is what exu sees.
  bundle_t mq[$];
  bundle_t pend[$];
  logic    m_ready;
  logic    last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] r1, input logic [31:0] r2);
    bundle_t b;
    b.inst  = $urandom;
    b.info  = $urandom | 32'h1;
    b.imm   = $urandom;
    b.pc    = pc;
    b.npc   = pc + 32'd4;
    b.rd    = 5'($urandom);
    b.rd_we = 1'($urandom);
    b.rs1   = rs1;
    b.rs2   = rs2;
    b.r1    = r1;
    b.r2    = r2;
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    inst_valid_i   = 1'b1;
    inst_i         = b.inst;
    dec_info_bus_i = b.info;
    dec_imm_i      = b.imm;
    dec_pc_i       = b.pc;
    next_pc_i      = b.npc;
    rd_waddr_i     = b.rd;
    rd_we_i        = b.rd_we;
    rs1_raddr_i    = b.rs1;
    rs2_raddr_i    = b.rs2;
    reg1_rdata_i   = b.r1;
    reg2_rdata_i   = b.r2;
  endtask

  task automatic idle_inputs();
    inst_valid_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    wb_we_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
  endtask

  function automatic logic hit(input logic [4:0] ra);
    return wb_we_i && wb_waddr_i != 0 && wb_waddr_i == ra;
  endfunction

  task automatic model_edge();
    logic acc, cons;
    bundle_t nb;
    acc  = inst_valid_i && m_ready;
    cons = (mq.size() > 0) && !hold_i;
    for (int i = 1; i < mq.size(); i++) begin
      if (hit(mq[i].rs1)) mq[i].r1 = wb_wdata_i;
      if (hit(mq[i].rs2)) mq[i].r2 = wb_wdata_i;
    end
    nb.inst = inst_i; nb.info = dec_info_bus_i; nb.imm = dec_imm_i;
    nb.pc = dec_pc_i; nb.npc = next_pc_i; nb.rd = rd_waddr_i; nb.rd_we = rd_we_i;
    nb.rs1 = rs1_raddr_i; nb.rs2 = rs2_raddr_i;
    nb.r1 = hit(rs1_raddr_i) ? wb_wdata_i : reg1_rdata_i;
    nb.r2 = hit(rs2_raddr_i) ? wb_wdata_i : reg2_rdata_i;
    if (flush_i) begin
      mq.delete();
      last_acc = 1'b0;
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(nb);
      last_acc = acc;
    end
    m_ready = (mq.size() < 2);
  endtask

  task automatic compare();
    chk("valid", {31'd0, inst_valid_o}, {31'd0, mq.size() > 0});
    chk("ready", {31'd0, inst_ready_o}, {31'd0, m_ready});
    if (mq.size() > 0) begin
      chk("inst", inst_o, mq[0].inst);
      chk("info", dec_info_bus_o, mq[0].info);
      chk("imm", dec_imm_o, mq[0].imm);
      chk("pc", dec_pc_o, mq[0].pc);
      chk("npc", next_pc_o, mq[0].npc);
      chk("rd", {27'd0, rd_waddr_o}, {27'd0, mq[0].rd});
      chk("rd_we", {31'd0, rd_we_o}, {31'd0, mq[0].rd_we});
      chk("reg1", reg1_rdata_o, mq[0].r1);
      chk("reg2", reg2_rdata_o, mq[0].r2);
    end else begin
      chk("empty_inst", inst_o, NOP);
      chk("empty_info", dec_info_bus_o, 32'd0);
      chk("empty_rd_we", {31'd0, rd_we_o}, 32'd0);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  // Offers pend[] in order; hmask bit c gives hold_i on offer cycle c.
  task automatic run(input logic [31:0] hmask);
    int c = 0;
    while ((pend.size() > 0 || mq.size() > 0) && c < 64) begin
      if (pend.size() > 0) drive(pend[0]); else inst_valid_i = 1'b0;
      hold_i = (c < 32) ? hmask[c] : 1'b0;
      step();
      if (last_acc) void'(pend.pop_front());
      c++;
    end
    idle_inputs();
  endtask

  initial begin
    bundle_t a, b;
    rst_n = 1'b0;
    idle_inputs();
    drive(mk(32'h0, 5'd0, 5'd0, 32'h0, 32'h0));
    inst_valid_i = 1'b0;
    m_ready = 1'b1;
    last_acc = 1'b0;
    #12;
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, inst_ready_o}, 32'd1);
    chk("rst_inst", inst_o, NOP);
    chk("rst_info", dec_info_bus_o, 32'd0);
    chk("rst_pc", dec_pc_o, 32'd0);
    chk("rst_reg1", reg1_rdata_o, 32'd0);
    chk("rst_reg2", reg2_rdata_o, 32'd0);
    rst_n = 1'b1;

    // Back-to-back stream, no hold.
    for (int i = 0; i < 4; i++) pend.push_back(mk(32'(i * 4), 5'd1, 5'd2, $urandom, $urandom));
    run(32'h0);

    // Hold for three cycles while streaming fills the skid entry.
    for (int i = 0; i < 4; i++) pend.push_back(mk(32'h100 + 32'(i * 4), 5'd3, 5'd4, $urandom, $urandom));
    run(32'b01110);

    // Flush while FULL and held.
    drive(mk(32'h200, 5'd1, 5'd1, 32'h1, 32'h2)); hold_i = 1'b0; step();
    drive(mk(32'h204, 5'd1, 5'd1, 32'h3, 32'h4)); hold_i = 1'b1; step();
    chk("full_ready", {31'd0, inst_ready_o}, 32'd0);
    drive(mk(32'h208, 5'd1, 5'd1, 32'h5, 32'h6)); flush_i = 1'b1; step();
    chk("flush_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("flush_info", dec_info_bus_o, 32'd0);
    chk("flush_inst", inst_o, NOP);
    chk("flush_ready", {31'd0, inst_ready_o}, 32'd1);
    idle_inputs(); step();

    // Flush in ONE drops a same-cycle accepted bundle.
    drive(mk(32'h300, 5'd2, 5'd2, 32'h7, 32'h8)); step();
    drive(mk(32'h304, 5'd2, 5'd2, 32'h9, 32'ha)); flush_i = 1'b1; step();
    chk("flush_drop", {31'd0, inst_valid_o}, 32'd0);
    idle_inputs(); step();

    // Writeback into skid entry in its move-to-out cycle.
    drive(mk(32'h400, 5'd3, 5'd6, 32'h1, 32'h2)); step();
    drive(mk(32'h404, 5'd5, 5'd6, 32'h11, 32'h22)); hold_i = 1'b1; step();
    inst_valid_i = 1'b0; hold_i = 1'b0;
    wb_we_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'hDEAD; step();
    chk("fwd_skid", reg1_rdata_o, 32'hDEAD);
    chk("fwd_skid_pc", dec_pc_o, 32'h404);
    idle_inputs(); step();

    // x0 never forwarded; the out entry is never patched.
    drive(mk(32'h500, 5'd7, 5'd0, 32'h77, 32'h0));
    wb_we_i = 1'b1; wb_waddr_i = 5'd0; wb_wdata_i = 32'hBEEF; step();
    chk("x0_in", reg2_rdata_o, 32'h0);
    drive(mk(32'h504, 5'd8, 5'd0, 32'h88, 32'h0)); hold_i = 1'b1; step();
    inst_valid_i = 1'b0; hold_i = 1'b1;
    wb_we_i = 1'b1; wb_waddr_i = 5'd7; wb_wdata_i = 32'h1234; step();
    chk("no_self_patch", reg1_rdata_o, 32'h77);
    hold_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'hBEEF; step();
    chk("x0_skid", reg2_rdata_o, 32'h0);
    chk("x0_skid_pc", dec_pc_o, 32'h504);
    idle_inputs(); step();

    // Randomized traffic with small register indices to provoke forwarding hits.
    for (int n = 0; n < 400; n++) begin
      a = mk($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      drive(a);
      inst_valid_i = ($urandom_range(0, 3) != 0);
      hold_i       = ($urandom_range(0, 2) == 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      wb_we_i      = 1'($urandom);
      wb_waddr_i   = 5'($urandom_range(0, 7));
      wb_wdata_i   = $urandom;
      step();
    end
    idle_inputs(); step(); step();

    // Asynchronous reset while FULL.
    drive(mk(32'h600, 5'd1, 5'd2, 32'h3, 32'h4)); step();
    b = mk(32'h604, 5'd1, 5'd2, 32'h5, 32'h6);
    drive(b); hold_i = 1'b1; step();
    idle_inputs(); hold_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("arst_ready", {31'd0, inst_ready_o}, 32'd1);
    chk("arst_inst", inst_o, NOP);
    chk("arst_pc", dec_pc_o, 32'd0);
    chk("arst_reg1", reg1_rdata_o, 32'd0);
    mq.delete();
    m_ready = 1'b1;
    #2 rst_n = 1'b1;
    hold_i = 1'b0;
    step();
    pend.push_back(mk(32'h700, 5'd1, 5'd2, $urandom, $urandom));
    run(32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/idu_exu_pipe.md
Name: idu_exu_pipe

Overview:
Decode-to-execute pipeline stage sitting directly upstream of exu. It registers the decoded instruction bundle and the GPR read data from idu, and presents them to exu. A two-entry skid buffer (out register plus skid register) keeps the upstream ready signal registered. The stage also honours exu hold and jump flush, and forwards same-cycle GPR writebacks into buffered operands.

Parameters:
DEC_INFO_W, `DECINFO_WIDTH, width of the decode info bus.
NOP_INST, 32'h00000013, value driven on inst_o when empty or after reset.

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
inst_valid_i  input  1  idu bundle valid
inst_ready_o  output  1  stage can accept a bundle (registered)
inst_i  input  32  instruction word
dec_info_bus_i  input  DEC_INFO_W  decode info
dec_imm_i  input  32  immediate
dec_pc_i  input  32  instruction PC
next_pc_i  input  32  PC+4
rd_waddr_i  input  5  destination register
rd_we_i  input  1  destination write enable
rs1_raddr_i  input  5  rs1 index
rs2_raddr_i  input  5  rs2 index
reg1_rdata_i  input  32  rs1 data
reg2_rdata_i  input  32  rs2 data
hold_i  input  1  exu hold_flag_o; out entry not consumed this cycle
flush_i  input  1  exu jump_flag_o; discard all younger bundles
wb_we_i  input  1  GPR commit pulse from exu (one cycle per committed instruction)
wb_waddr_i  input  5  commit register index
wb_wdata_i  input  32  commit data
inst_valid_o  output  1  bundle valid to exu
inst_o  output  32  instruction to exu
dec_info_bus_o  output  DEC_INFO_W  decode info to exu
dec_imm_o  output  32  immediate to exu
dec_pc_o  output  32  PC to exu
next_pc_o  output  32  next PC to exu
rd_waddr_o  output  5  destination register to exu
rd_we_o  output  1  destination write enable to exu
reg1_rdata_o  output  32  rs1 data to exu
reg2_rdata_o  output  32  rs2 data to exu

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, skid_valid=0, inst_ready_o=1.
  - inst_o=NOP_INST.
  - All other outputs 0.
- Empty-output rule: while out_valid=0, drive:
  - inst_valid_o=0, dec_info_bus_o=0, rd_we_o=0, inst_o=NOP_INST.
  - This prevents exu from dispatching stale decode info.
- Definitions:
  - consume = out_valid & ~hold_i.
  - accept = inst_valid_i & inst_ready_o.
- inst_ready_o is registered: next value = ~skid_valid_next.
- Flush (highest priority): when flush_i=1, next cycle out_valid=0 and skid_valid=0, and inst_ready_o=1. A bundle accepted in the same cycle is dropped. Flush while hold_i=1 still clears both entries.
- Otherwise, transitions (state = {out_valid, skid_valid}):
  - EMPTY {0,0}: accept -> out, giving {1,0}.
  - ONE {1,0}, consume & accept: out <= input, stay {1,0}.
  - ONE {1,0}, consume & ~accept: {0,0}.
  - ONE {1,0}, ~consume & accept: skid <= input, giving {1,1} (inst_ready_o drops next cycle).
  - ONE {1,0}, ~consume & ~accept: no change.
  - FULL {1,1}, consume: out <= skid, giving {1,0}. No accept is possible because inst_ready_o=0.
  - FULL {1,1}, ~consume: no change.
- Throughput: one bundle per cycle sustained when hold_i=0. Latency idu to exu is one cycle.
- Writeback forwarding:
  - A match requires wb_we_i=1 & wb_waddr_i!=0 & wb_waddr_i==raddr.
  - Input path: when accepting, the captured rsX data is wb_wdata_i on a match, else regX_rdata_i.
  - Skid entry: each cycle it is valid, a match overwrites the stored rsX data. This applies also in the cycle it moves to out, so the moved value is already patched.
  - The out entry is never patched, because it is the producing instruction.
  - rs1 and rs2 are handled independently; both patched if both match.
- Entry contents hold stable while not moving, with no glitching on outputs. All outputs are driven from flops except the empty-output masking.
- rs1_raddr/rs2_raddr are stored per entry for forwarding only; they are not output.

Test Plan:
- Reset then stream: 4 bundles PC 0x00,0x04,0x08,0x0C with hold_i=0 -> inst_valid_o=1 on cycles 1-4 with matching dec_pc_o. inst_ready_o stays 1 throughout.
- Hold backpressure: hold_i=1 for 3 cycles while streaming -> skid fills and inst_ready_o=0 from the 2nd hold cycle. Outputs stay on the first bundle. After release, order is preserved with no loss or duplication.
- Flush in FULL: set {1,1}, flush_i=1 together with hold_i=1 -> next cycle inst_valid_o=0, dec_info_bus_o=0, inst_o=0x00000013, inst_ready_o=1.
- Forwarding into skid: skid holds rs1=x5 with data 0x11. wb_we_i=1, wb_waddr_i=5, wb_wdata_i=0xDEAD in the same cycle as consume -> next cycle reg1_rdata_o=0xDEAD.
- x0 and no self-patch: wb_waddr_i=0 matching rs2=x0 -> stored 0 unchanged. An out entry with rs1=x7, held with wb to x7 -> reg1_rdata_o unchanged.
- Async reset mid-FULL: drop rst_n between clock edges -> outputs reset immediately, with inst_valid_o=0 before the next edge.
